imem_program_loader: RTL and testbench



---
 rtl/mips_pkg.sv | 57 +++++
 rtl/instr_encoder.sv | 45 ++++
 rtl/imem_program_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_program_loader.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode map (common with the main decoder), loader
// mnemonic codes, loader FSM encoding and the instruction-field payload.
package mips_pkg;

  localparam int unsigned WORD_W = 32;

  // Primary opcodes, bits [31:26] of the machine word
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Symbolic mnemonic codes on the programming port; 13..15 are illegal
  typedef enum logic [3:0] {
    MN_RTYPE = 4'd0,
    MN_J     = 4'd1,
    MN_JAL   = 4'd2,
    MN_BEQ   = 4'd3,
    MN_BNE   = 4'd4,
    MN_ADDI  = 4'd5,
    MN_SLTI  = 4'd6,
    MN_ANDI  = 4'd7,
    MN_ORI   = 4'd8,
    MN_XORI  = 4'd9,
    MN_LUI   = 4'd10,
    MN_LW    = 4'd11,
    MN_SW    = 4'd12
  } mnem_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Raw instruction fields as presented by the host
  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } fields_t;

endpackage

// File: rtl/instr_encoder.sv
// Combinational instruction encoder: symbolic mnemonic + fields -> 32-bit
// machine word. Inverse of the main decoder's opcode map.
// Ports:
//   mnem_i    mnemonic code (0..12 legal)
//   fields_i  rs/rt/rd/shamt/funct/imm/target payload
//   word_o    encoded machine word (0 when illegal)
//   illegal_o mnemonic code has no encoding
module instr_encoder
  import mips_pkg::*;
(
  input  logic [3:0]        mnem_i,
  input  fields_t           fields_i,
  output logic [WORD_W-1:0] word_o,
  output logic              illegal_o
);

  // I-type layout shared by branches, ALU-immediates and loads/stores
  function automatic logic [WORD_W-1:0] itype(input logic [5:0] op, input fields_t f);
    return {op, f.rs, f.rt, f.imm};
  endfunction

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (mnem_i)
      MN_RTYPE: word_o = {OP_RTYPE, fields_i.rs, fields_i.rt, fields_i.rd,
                          fields_i.shamt, fields_i.funct};
      MN_J:     word_o = {OP_J, fields_i.target};
      MN_JAL:   word_o = {OP_JAL, fields_i.target};
      MN_BEQ:   word_o = itype(OP_BEQ, fields_i);
      MN_BNE:   word_o = itype(OP_BNE, fields_i);
      MN_ADDI:  word_o = itype(OP_ADDI, fields_i);
      MN_SLTI:  word_o = itype(OP_SLTI, fields_i);
      MN_ANDI:  word_o = itype(OP_ANDI, fields_i);
      MN_ORI:   word_o = itype(OP_ORI, fields_i);
      MN_XORI:  word_o = itype(OP_XORI, fields_i);
      // lui has no source register; rs is forced to zero
      MN_LUI:   word_o = {OP_LUI, 5'd0, fields_i.rt, fields_i.imm};
      MN_LW:    word_o = itype(OP_LW, fields_i);
      MN_SW:    word_o = itype(OP_SW, fields_i);
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader. Accepts a stream of symbolic instruction
// field sets, encodes each into a machine word and writes it to consecutive
// word addresses starting at 0. Holds the core in reset until a load finishes
// cleanly.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   start                         pulse: begin (or restart) a load at address 0
//   in_valid/in_ready/in_last     field-set handshake, last-beat marker
//   mnem, rs, rt, rd, shamt,
//   funct, imm, target            instruction fields
//   imem_we/imem_addr/imem_wdata  instruction-memory write port (registered)
//   count                         words written in the current load
//   busy, done, err               status
//   cpu_rst_n                     active-low core reset, high only in DONE
module imem_program_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_n
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                last_q, last_d;
  logic                in_ready_q, in_ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cpu_rst_n_q, cpu_rst_n_d;

  fields_t             fields_c;
  logic [WORD_W-1:0]   word_c;
  logic                illegal_c;
  logic                accept_c;

  always_comb begin
    fields_c.rs     = rs;
    fields_c.rt     = rt;
    fields_c.rd     = rd;
    fields_c.shamt  = shamt;
    fields_c.funct  = funct;
    fields_c.imm    = imm;
    fields_c.target = target;
  end

  instr_encoder u_encoder (
    .mnem_i    (mnem),
    .fields_i  (fields_c),
    .word_o    (word_c),
    .illegal_o (illegal_c)
  );

  assign accept_c = in_valid && in_ready_q;

  // State, counter and write-port registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  // Next-state, counter and write-port logic
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LOAD;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        if (start) begin
          // Restart; a beat handshaken this cycle is dropped
          count_d = '0;
        end else if (last_q) begin
          // Final write is on the port now; report DONE only after it
          state_d = ST_DONE;
        end else if (in_valid && (count_q == CAP)) begin
          // Memory full: a further beat is an overflow, never a wrap
          state_d = ST_ERR;
        end else if (accept_c) begin
          if (illegal_c) begin
            state_d = ST_ERR;
          end else begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = word_c;
            count_d = count_q + CNT_W'(1);
            last_d  = in_last;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs follow the next state so they change on the same edge
    in_ready_d  = (state_d == ST_LOAD) && !last_d && (count_d < CAP);
    busy_d      = (state_d == ST_LOAD);
    done_d      = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERR);
    cpu_rst_n_d = (state_d == ST_DONE);
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cpu_rst_n  = cpu_rst_n_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: directed test-plan cases plus
// randomized loads against a behavioural model, with a scoreboard monitor on
// the instruction-memory write port.
module tb_imem_program_loader;

  localparam int unsigned AW  = 4;
  localparam int unsigned CAP = 1 << AW;
  // Opcode per mnemonic code 0..12, lowest code in the lowest 6 bits
  localparam logic [77:0] OPC = {6'h2B, 6'h23, 6'h0F, 6'h0E, 6'h0D, 6'h0C, 6'h0A,
                                 6'h08, 6'h05, 6'h04, 6'h03, 6'h02, 6'h00};

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [3:0]    mnem;
  logic [4:0]    rs, rt, rd, shamt;
  logic [5:0]    funct;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          busy, done, err, cpu_rst_n;

  imem_program_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .mnem       (mnem),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .funct      (funct),
    .imm        (imm),
    .target     (target),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_rst_n  (cpu_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t q[$];
  int  n_tests;
  int  n_fail;
  int  cyc;
  bit  loading;
  bit  merr;
  int  mcount;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // {busy, done, err, cpu_rst_n}
  task automatic chk_status(input string name, input logic [3:0] exp);
    chk(name, 32'({busy, done, err, cpu_rst_n}), 32'(exp));
  endtask

  function automatic logic [31:0] model_enc(input int mn, input logic [4:0] frs, input logic [4:0] frt,
                                            input logic [4:0] frd, input logic [4:0] fsh,
                                            input logic [5:0] ffn, input logic [15:0] fimm,
                                            input logic [25:0] ftgt);
    logic [5:0] op;
    op = OPC[mn*6 +: 6];
    if (mn == 0) return {6'h00, frs, frt, frd, fsh, ffn};
    if (mn <= 2) return {op, ftgt};
    if (mn == 10) frs = 5'd0;
    return {op, frs, frt, fimm};
  endfunction

  task automatic set_fields(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                            input logic [4:0] s, input logic [5:0] f, input logic [15:0] i,
                            input logic [25:0] t);
    rs = a; rt = b; rd = c; shamt = s; funct = f; imm = i; target = t;
  endtask

  task automatic rand_fields();
    set_fields(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               6'($urandom), 16'($urandom), 26'($urandom));
  endtask

  // Present one beat; if use_exp, the expected word is the given literal
  task automatic present_x(input logic [3:0] mn, input logic last,
                           input bit use_exp, input logic [31:0] exp_word);
    bit exp_rdy;
    wr_t e;
    mnem = mn; in_last = last; in_valid = 1'b1;
    exp_rdy = loading && (mcount < CAP);
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (loading) begin
      if (!exp_rdy || mn > 4'd12) begin
        loading = 0; merr = 1;
      end else begin
        e.cyc  = cyc;
        e.addr = mcount;
        e.data = use_exp ? exp_word
                         : model_enc(int'(mn), rs, rt, rd, shamt, funct, imm, target);
        q.push_back(e);
        mcount++;
        if (last) loading = 0;
      end
    end
  endtask

  task automatic present(input logic [3:0] mn, input logic last);
    present_x(mn, last, 1'b0, 32'h0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    loading = 1; merr = 0; mcount = 0;
    chk_status("start_status", 4'b1000);
    chk("start_count", 32'(count), 32'h0);
    chk("start_in_ready", 32'(in_ready), 32'h1);
  endtask

  // Called right after the last beat was accepted
  task automatic finish_load();
    @(negedge clk);
    chk_status("write_cycle_status", 4'b1000);
    @(posedge clk); #1;
    chk_status("done_status", 4'b0101);
    chk("done_count", 32'(count), 32'(mcount));
    chk("pending_writes", 32'(q.size()), 32'h0);
  endtask

  task automatic check_err();
    chk_status("err_status", 4'b0010);
    chk("err_count", 32'(count), 32'(mcount));
    chk("err_in_ready", 32'(in_ready), 32'h0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n && imem_we) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: addr=%0d data=0x%08h, no write expected", imem_addr, imem_wdata);
        end else begin
          wr_t e;
          e = q.pop_front();
          chk("write_cycle", 32'(cyc), 32'(e.cyc));
          chk("write_addr", 32'(imem_addr), 32'(e.addr));
          chk("write_data", imem_wdata, e.data);
        end
      end
    end
  endtask

  task automatic cycle_counter();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    loading = 0; merr = 0; mcount = 0;
    start = 0; in_valid = 0; in_last = 0; mnem = '0;
    set_fields('0, '0, '0, '0, '0, '0, '0);
    rst_n = 1'b1;
    fork
      monitor();
      cycle_counter();
    join_none

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_ctrl", 32'({in_ready, imem_we, imem_addr, count, busy, done, err, cpu_rst_n}), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_status("idle_status", 4'b0000);
    chk("idle_in_ready", 32'(in_ready), 32'h0);

    // Single addi with last
    do_start();
    set_fields(5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0);
    present_x(4'd5, 1'b1, 1'b1, 32'h20080005);
    finish_load();

    // Back-to-back 4-beat stream
    do_start();
    set_fields(5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 26'h0);
    present_x(4'd0, 1'b0, 1'b1, 32'h01095020);
    set_fields(5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10);
    present_x(4'd1, 1'b0, 1'b1, 32'h08000010);
    set_fields(5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h4, 26'h0);
    present_x(4'd12, 1'b0, 1'b1, 32'hAFA80004);
    set_fields(5'd8, 5'd9, 5'd0, 5'd0, 6'h0, 16'hFFFE, 26'h0);
    present_x(4'd4, 1'b1, 1'b1, 32'h1509FFFE);
    finish_load();
    chk("stream_count", 32'(count), 32'h4);

    // lui zeroes rs
    do_start();
    set_fields(5'd5, 5'd1, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0);
    present_x(4'd10, 1'b1, 1'b1, 32'h3C011234);
    finish_load();

    // Illegal mnemonic as 2nd beat
    do_start();
    set_fields(5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0);
    present(4'd5, 1'b0);
    present(4'd14, 1'b0);
    check_err();
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    chk_status("err_sticky", 4'b0010);
    chk("err_pending", 32'(q.size()), 32'h0);
    do_start();
    present(4'd7, 1'b1);
    finish_load();

    // Restart from DONE, then start during LOAD with a beat on the port
    do_start();
    rand_fields(); present(4'd8, 1'b0);
    rand_fields(); present(4'd9, 1'b0);
    start = 1'b1; in_valid = 1'b1; in_last = 1'b1; mnem = 4'd5;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    loading = 1; merr = 0; mcount = 0;
    chk("restart_count", 32'(count), 32'h0);
    chk_status("restart_status", 4'b1000);
    rand_fields(); present(4'd11, 1'b1);
    finish_load();

    // Overflow: fill memory, then one more beat
    do_start();
    for (int i = 0; i < int'(CAP); i++) begin
      rand_fields();
      present(4'($urandom_range(0, 12)), 1'b0);
    end
    rand_fields();
    present(4'd5, 1'b0);
    check_err();
    chk("ovf_pending", 32'(q.size()), 32'h0);
    repeat (2) @(posedge clk);
    #1 chk_status("ovf_sticky", 4'b0010);

    // Randomized loads
    for (int l = 0; l < 25; l++) begin
      int len;
      do_start();
      len = int'($urandom_range(1, 12));
      for (int b = 0; b < len && !merr; b++) begin
        logic [3:0] mn;
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        mn = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(13, 15))
                                          : 4'($urandom_range(0, 12));
        rand_fields();
        present(mn, b == len - 1);
      end
      if (merr) check_err();
      else finish_load();
    end

    // Asynchronous reset mid-stream with a write in flight
    do_start();
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      present(4'd5, 1'b0);
    end
    in_valid = 1'b1; mnem = 4'd6;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_wdata", imem_wdata, 32'h0);
    chk("mid_rst_ctrl", 32'({in_ready, imem_we, imem_addr, count, busy, done, err, cpu_rst_n}), 32'h0);
    q.delete();
    loading = 0; mcount = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_we", 32'(imem_we), 32'h0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_status("post_rst_idle", 4'b0000);
      chk("post_rst_in_ready", 32'(in_ready), 32'h0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
